ex_md: RTL and testbench

//  Execute stage with multiply/divide support, the next generation of the EX stage.

---
 rtl/ex_md_pkg.sv | 41 ++++
 rtl/ex_md_div.sv | 125 ++++++++++++
 rtl/ex_md.sv | 138 +++++++++++++
 tb/tb_ex_md.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_md_pkg.sv
// Shared opcodes, result-select codes and divider state encoding for the
// multiply/divide execute stage.
package ex_md_pkg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;

    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_md_div.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up applied on the registered result while in DONE.
module div_iter
    import ex_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              signed_i,
    input  logic              hold,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e        state_reg, state_next;
    logic [DATA_W-1:0] quo_reg, quo_next;
    logic [DATA_W-1:0] rem_reg, rem_next;
    logic [DATA_W-1:0] dvs_reg, dvs_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              neg_q_reg, neg_q_next;
    logic              neg_r_reg, neg_r_next;

    logic [DATA_W-1:0] abs_dvd, abs_dvs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    assign abs_dvd = (signed_i && dividend[DATA_W-1]) ? -dividend : dividend;
    assign abs_dvs = (signed_i && divisor[DATA_W-1])  ? -divisor  : divisor;

    // Partial remainder stays below the divisor, so shifted < 2*divisor and
    // bit DATA_W of the difference is a clean borrow flag.
    assign shifted = {rem_reg, quo_reg[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs_reg};

    always_comb begin
        state_next = state_reg;
        quo_next   = quo_reg;
        rem_next   = rem_reg;
        dvs_next   = dvs_reg;
        cnt_next   = cnt_reg;
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
        busy       = 1'b0;
        if (abort) begin
            state_next = DIV_IDLE;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (start) begin
                        busy = 1'b1;
                        if (divisor == '0) begin
                            quo_next   = '1;
                            rem_next   = dividend;
                            neg_q_next = 1'b0;
                            neg_r_next = 1'b0;
                            state_next = DIV_DONE;
                        end else begin
                            quo_next   = abs_dvd;
                            rem_next   = '0;
                            dvs_next   = abs_dvs;
                            cnt_next   = CNT_W'(DATA_W);
                            neg_q_next = signed_i && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                            neg_r_next = signed_i && dividend[DATA_W-1];
                            state_next = DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    busy = 1'b1;
                    if (!diff[DATA_W]) begin
                        rem_next = diff[DATA_W-1:0];
                        quo_next = {quo_reg[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_next = shifted[DATA_W-1:0];
                        quo_next = {quo_reg[DATA_W-2:0], 1'b0};
                    end
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!hold) begin
                        state_next = DIV_IDLE;
                    end
                end
                default: state_next = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= DIV_IDLE;
            quo_reg   <= '0;
            rem_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            quo_reg   <= quo_next;
            rem_reg   <= rem_next;
            dvs_reg   <= dvs_next;
            cnt_reg   <= cnt_next;
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
        end
    end

    assign ready     = (state_reg == DIV_DONE);
    assign quotient  = neg_q_reg ? -quo_reg : quo_reg;
    assign remainder = neg_r_reg ? -rem_reg : rem_reg;

endmodule

// File: rtl/ex_md.sv
// Execute stage: logic/shift/arith result mux, single-cycle multiplier,
// HI/LO registers and an iterative divider that stalls the pipeline.
module ex_md
    import ex_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [DATA_W-1:0]   reg1_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic [4:0]          wd_i,
    input  logic                wreg_i,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic [4:0]          wd_o,
    output logic                wreg_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                stall_req_o
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   hi_reg, hi_next, lo_reg, lo_next;
    logic [DATA_W-1:0]   logic_res, shift_res, arith_res, move_res;
    logic [2*DATA_W-1:0] mul_s, mul_u;
    logic [SHAMT_W-1:0]  shamt;
    logic                div_start, div_busy, div_ready;
    logic [DATA_W-1:0]   div_q, div_r;

    assign shamt = reg1_i[SHAMT_W-1:0];

    // Sign-extending to full width lets a plain modular multiply produce the signed product.
    assign mul_s = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
    assign mul_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (aluop_i)
            EXE_OR_OP:   logic_res = reg1_i | reg2_i;
            EXE_AND_OP:  logic_res = reg1_i & reg2_i;
            EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
            default:     logic_res = '0;
        endcase
        case (aluop_i)
            EXE_SLL_OP:  shift_res = reg2_i << shamt;
            EXE_SRL_OP:  shift_res = reg2_i >> shamt;
            EXE_SRA_OP:  shift_res = unsigned'($signed(reg2_i) >>> shamt);
            default:     shift_res = '0;
        endcase
        case (aluop_i)
            EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
            EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
            EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            default:     arith_res = '0;
        endcase
        case (aluop_i)
            EXE_MFHI_OP: move_res = hi_reg;
            EXE_MFLO_OP: move_res = lo_reg;
            default:     move_res = '0;
        endcase
    end

    always_comb begin
        wdata_o = '0;
        if (rst) begin
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                EXE_RES_ARITH: wdata_o = arith_res;
                EXE_RES_MOVE:  wdata_o = move_res;
                default:       wdata_o = '0;
            endcase
        end
    end

    assign wd_o   = rst ? wd_i : 5'd0;
    assign wreg_o = rst & wreg_i;

    // A finished divide owns HI/LO on its final edge; the DIV op is still in EX then.
    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        if (!flush_i) begin
            if (div_ready && !stall_i) begin
                lo_next = div_q;
                hi_next = div_r;
            end else begin
                case (aluop_i)
                    EXE_MULT_OP:  {hi_next, lo_next} = mul_s;
                    EXE_MULTU_OP: {hi_next, lo_next} = mul_u;
                    EXE_MTHI_OP:  hi_next = reg1_i;
                    EXE_MTLO_OP:  lo_next = reg1_i;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
        end
    end

    assign div_start = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

    div_iter #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush_i),
        .signed_i  (aluop_i == EXE_DIV_OP),
        .hold      (stall_i),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .busy      (div_busy),
        .ready     (div_ready),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign stall_req_o = rst & div_busy;

endmodule

// File: tb/tb_ex_md.sv
// Directed bench for ex_md: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares whenever an instruction leaves EX.
module tb_ex_md;
    import ex_md_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    aluop;
    logic [2:0]    alusel;
    logic [W-1:0]  reg1, reg2;
    logic [4:0]    wd;
    logic          wreg;
    logic          stall_i, flush_i;
    logic [4:0]    wd_o;
    logic          wreg_o;
    logic [W-1:0]  wdata_o;
    logic          stall_req_o;

    int            total = 0;
    int            bad = 0;
    int            stalls = 0;
    logic          tb_valid = 1'b0;
    logic [W-1:0]  exp_q[$];
    string         name_q[$];

    ex_md #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop),
        .alusel_i    (alusel),
        .reg1_i      (reg1),
        .reg2_i      (reg2),
        .wd_i        (wd),
        .wreg_i      (wreg),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, expv);
        end else begin
            $display("ok   %s: %08h", nm, act);
        end
    endtask

    // Monitor: an instruction retires in the cycle where EX is not stalled.
    always @(negedge clk) begin
        string        nm;
        logic [W-1:0] e;
        if (rst && tb_valid && !stall_req_o && !stall_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %08h want none", wdata_o);
            end else begin
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                check(nm, wdata_o, e);
            end
        end
    end

    task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit chk, input logic [W-1:0] e, input string nm);
        int guard;
        guard  = 0;
        aluop  = op;
        alusel = sel;
        reg1   = a;
        reg2   = b;
        wd     = 5'd3;
        wreg   = 1'b1;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        tb_valid = chk;
        stalls   = 0;
        do begin
            @(negedge clk);
            if (stall_req_o) stalls++;
            guard++;
        end while ((stall_req_o || stall_i) && guard < 200);
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d cycles want <200", nm, guard);
        end
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
    endtask

    task automatic rd_move(input logic [7:0] op, input logic [W-1:0] e, input string nm);
        issue(op, EXE_RES_MOVE, '0, '0, 1'b1, e, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stall_i = 1'b0;
        flush_i = 1'b0;
        aluop   = EXE_OR_OP;
        alusel  = EXE_RES_LOGIC;
        reg1    = 32'hA5A5_A5A5;
        reg2    = 32'h0000_0001;
        wd      = 5'd7;
        wreg    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_wd", {27'd0, wd_o}, 32'h0);
        check("rst_wreg", {31'd0, wreg_o}, 32'h0);
        check("rst_stall", {31'd0, stall_req_o}, 32'h0);
        check("rst_hi", dut.hi_reg, 32'h0);
        check("rst_lo", dut.lo_reg, 32'h0);
        @(posedge clk);
        #1;
        aluop = EXE_NOP_OP;
        rst   = 1'b1;
        @(posedge clk);
        #1;

        // Logic / shift / arithmetic
        issue(EXE_OR_OP,   EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 1, 32'hF0F0_0F0F, "or");
        issue(EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00, "and");
        issue(EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hF0F0_0F0F, "xor");
        issue(EXE_NOR_OP,  EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0000_000F, 1, 32'h0000_FFF0, "nor");
        issue(EXE_OR_OP,   3'b111,        32'h1234_5678, 32'h1,         1, 32'h0,         "bad_sel");
        issue(EXE_SLL_OP,  EXE_RES_SHIFT, 32'd4, 32'h0000_000F,         1, 32'h0000_00F0, "sll");
        issue(EXE_SRL_OP,  EXE_RES_SHIFT, 32'd4, 32'h8000_0000,         1, 32'h0800_0000, "srl");
        issue(EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4, 32'h8000_0000,         1, 32'hF800_0000, "sra");
        issue(EXE_ADDU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1,         1, 32'h0,         "addu_wrap");
        issue(EXE_SUBU_OP, EXE_RES_ARITH, 32'd0, 32'd1,                 1, 32'hFFFF_FFFF, "subu_wrap");
        issue(EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1,         1, 32'd1,         "slt");
        issue(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1,         1, 32'd0,         "sltu");

        // Multiply and moves
        issue(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFD, 32'd5, 0, '0, "mult");
        rd_move(EXE_MFLO_OP, 32'hFFFF_FFF1, "mult_lo");
        rd_move(EXE_MFHI_OP, 32'hFFFF_FFFF, "mult_hi");
        issue(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2, 0, '0, "multu");
        rd_move(EXE_MFHI_OP, 32'h0000_0001, "multu_hi");
        rd_move(EXE_MFLO_OP, 32'hFFFF_FFFE, "multu_lo");
        issue(EXE_MTHI_OP, EXE_RES_NOP, 32'h1234_5678, '0, 0, '0, "mthi");
        issue(EXE_MTLO_OP, EXE_RES_NOP, 32'h9ABC_DEF0, '0, 0, '0, "mtlo");
        rd_move(EXE_MFHI_OP, 32'h1234_5678, "mthi_rd");
        rd_move(EXE_MFLO_OP, 32'h9ABC_DEF0, "mtlo_rd");

        // Divides
        issue(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2, 0, '0, "div_m7_2");
        check("div_stalls", 32'(stalls), 32'd33);
        rd_move(EXE_MFLO_OP, 32'hFFFF_FFFD, "div_m7_2_lo");
        rd_move(EXE_MFHI_OP, 32'hFFFF_FFFF, "div_m7_2_hi");
        issue(EXE_DIV_OP, EXE_RES_NOP, 32'd7, 32'hFFFF_FFFE, 0, '0, "div_7_m2");
        rd_move(EXE_MFLO_OP, 32'hFFFF_FFFD, "div_7_m2_lo");
        rd_move(EXE_MFHI_OP, 32'h0000_0001, "div_7_m2_hi");
        issue(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 0, '0, "divu");
        check("divu_stalls", 32'(stalls), 32'd33);
        rd_move(EXE_MFLO_OP, 32'd14, "divu_lo");
        rd_move(EXE_MFHI_OP, 32'd2, "divu_hi");
        issue(EXE_DIV_OP, EXE_RES_NOP, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, "div_ovf");
        rd_move(EXE_MFLO_OP, 32'h8000_0000, "div_ovf_lo");
        rd_move(EXE_MFHI_OP, 32'h0, "div_ovf_hi");
        issue(EXE_DIV_OP, EXE_RES_NOP, 32'h0000_1234, 32'd0, 0, '0, "div_zero");
        check("divz_stalls", 32'(stalls), 32'd1);
        rd_move(EXE_MFLO_OP, 32'hFFFF_FFFF, "divz_lo");
        rd_move(EXE_MFHI_OP, 32'h0000_1234, "divz_hi");

        // Flush on cycle 10 of a divide
        aluop  = EXE_DIV_OP;
        alusel = EXE_RES_NOP;
        reg1   = 32'd1000;
        reg2   = 32'd3;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("flush_pre_stall", {31'd0, stall_req_o}, 32'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        rd_move(EXE_MFHI_OP, 32'h0000_1234, "flush_hi");
        check("flush_idle", 32'(stalls), 32'd0);
        rd_move(EXE_MFLO_OP, 32'hFFFF_FFFF, "flush_lo");

        // stall_i held through DONE defers the HI/LO write
        issue(EXE_MTHI_OP, EXE_RES_NOP, 32'hAAAA_0000, '0, 0, '0, "mthi2");
        issue(EXE_MTLO_OP, EXE_RES_NOP, 32'h0000_BBBB, '0, 0, '0, "mtlo2");
        stall_i = 1'b1;
        aluop   = EXE_DIVU_OP;
        alusel  = EXE_RES_NOP;
        reg1    = 32'd100;
        reg2    = 32'd7;
        begin
            int g;
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (stall_req_o && g < 200);
            if (g >= 200) begin
                total++;
                bad++;
                $display("FAIL hold_timeout: got %0d cycles want <200", g);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_hi", dut.hi_reg, 32'hAAAA_0000);
            check("hold_lo", dut.lo_reg, 32'h0000_BBBB);
        end
        @(posedge clk);
        #1;
        stall_i = 1'b0;
        @(negedge clk);
        check("hold_release_hi", dut.hi_reg, 32'hAAAA_0000);
        @(posedge clk);
        #1;
        rd_move(EXE_MFLO_OP, 32'd14, "hold_lo_written");
        check("hold_no_restart", 32'(stalls), 32'd0);
        rd_move(EXE_MFHI_OP, 32'd2, "hold_hi_written");

        // Reset in the middle of a divide
        aluop  = EXE_DIV_OP;
        alusel = EXE_RES_NOP;
        reg1   = 32'd1000;
        reg2   = 32'd3;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst_pre_stall", {31'd0, stall_req_o}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall_req_o}, 32'd0);
        check("midrst_wdata", wdata_o, 32'h0);
        check("midrst_wreg", {31'd0, wreg_o}, 32'd0);
        check("midrst_hi", dut.hi_reg, 32'h0);
        check("midrst_lo", dut.lo_reg, 32'h0);
        aluop = EXE_NOP_OP;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_move(EXE_MFHI_OP, 32'h0, "post_rst_hi");
        check("post_rst_stalls", 32'(stalls), 32'd0);
        rd_move(EXE_MFLO_OP, 32'h0, "post_rst_lo");

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
